// File: rtl/m_mem_arbiter.sv
// Round-robin arbiter sharing one cached-memory request port between the
// instruction-fetch port and the load/store port, one transaction at a time.
module m_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  rst,
   input  logic                  i_if_req,
   input  logic [ADDR_WIDTH-1:0] i_if_addr,
   output logic                  o_if_ack,
   output logic [DATA_WIDTH-1:0] o_if_data,
   input  logic                  i_d_ren,
   input  logic [3:0]            i_d_wen,
   input  logic [ADDR_WIDTH-1:0] i_d_addr,
   input  logic [DATA_WIDTH-1:0] i_d_data,
   output logic                  o_d_ack,
   output logic [DATA_WIDTH-1:0] o_d_data,
   output logic                  o_mem_ren,
   output logic [3:0]            o_mem_wen,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_data,
   input  logic [DATA_WIDTH-1:0] i_mem_data,
   input  logic                  i_mem_stall,
   output logic                  o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                state, state_nxt;
   logic                  dreq, grant_if, grant_d;
   logic                  lg, owner, is_write;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q, if_data_q, d_data_q;
   logic [3:0]            wen_q;
   logic                  if_ack_q, d_ack_q;
   logic                  done;

   assign dreq = i_d_ren | (|i_d_wen);
   assign done = (state == S_WAIT) && !i_mem_stall;

   always_ff @(posedge i_clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_d   = 1'b0;
      case (state)
         S_IDLE: begin
            // On a tie the data port wins only if fetch was granted last.
            grant_d  = dreq & (~i_if_req | ~lg);
            grant_if = i_if_req & ~grant_d;
            if (grant_if || grant_d) state_nxt = S_ISSUE;
         end
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (!i_mem_stall) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (rst) begin
         lg        <= 1'b1;
         owner     <= 1'b0;
         is_write  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         wen_q     <= '0;
         if_ack_q  <= 1'b0;
         d_ack_q   <= 1'b0;
         if_data_q <= '0;
         d_data_q  <= '0;
      end else begin
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         if (grant_if) begin
            owner    <= 1'b0;
            addr_q   <= i_if_addr;
            data_q   <= '0;
            wen_q    <= '0;
            is_write <= 1'b0;
         end else if (grant_d) begin
            owner    <= 1'b1;
            addr_q   <= i_d_addr;
            data_q   <= i_d_data;
            wen_q    <= i_d_wen;
            is_write <= |i_d_wen;
         end
         // Ack is registered here so it is high exactly during RESP.
         if (done) begin
            lg <= owner;
            if (owner) d_ack_q  <= 1'b1;
            else       if_ack_q <= 1'b1;
            if (!is_write) begin
               if (owner) d_data_q  <= i_mem_data;
               else       if_data_q <= i_mem_data;
            end
         end
      end
   end

   assign o_mem_ren  = (state == S_ISSUE) && !is_write;
   assign o_mem_wen  = (state == S_ISSUE) ? wen_q : 4'd0;
   assign o_mem_addr = addr_q;
   assign o_mem_data = data_q;
   assign o_if_ack   = if_ack_q;
   assign o_d_ack    = d_ack_q;
   assign o_if_data  = if_data_q;
   assign o_d_data   = d_data_q;
   assign o_busy     = (state != S_IDLE);

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Self-checking bench for m_mem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level timing model.
module tb_m_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          i_clk, rst;
   logic          i_if_req;
   logic [AW-1:0] i_if_addr;
   logic          o_if_ack;
   logic [DW-1:0] o_if_data;
   logic          i_d_ren;
   logic [3:0]    i_d_wen;
   logic [AW-1:0] i_d_addr;
   logic [DW-1:0] i_d_data;
   logic          o_d_ack;
   logic [DW-1:0] o_d_data;
   logic          o_mem_ren;
   logic [3:0]    o_mem_wen;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_data;
   logic [DW-1:0] i_mem_data;
   logic          i_mem_stall;
   logic          o_busy;

   int checks = 0;
   int errors = 0;

   m_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .i_clk(i_clk), .rst(rst),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_ack(o_if_ack), .o_if_data(o_if_data),
      .i_d_ren(i_d_ren), .i_d_wen(i_d_wen), .i_d_addr(i_d_addr), .i_d_data(i_d_data),
      .o_d_ack(o_d_ack), .o_d_data(o_d_data),
      .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
      .o_mem_data(o_mem_data), .i_mem_data(i_mem_data), .i_mem_stall(i_mem_stall),
      .o_busy(o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_if_req = 0; i_if_addr = '0; i_d_ren = 0; i_d_wen = 0;
      i_d_addr = '0; i_d_data = '0; i_mem_data = '0; i_mem_stall = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1; tick(); tick(); rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1; i_if_req = 1; i_if_addr = 32'h55; i_d_ren = 1;
      tick(); tick();
      checks++;
      if ({o_busy, o_if_ack, o_d_ack, o_mem_ren, o_mem_wen} !== 8'd0) begin
         errors++; $display("FAIL reset_ctrl: got %b required 0", {o_busy, o_if_ack, o_d_ack, o_mem_ren, o_mem_wen});
      end
      checks++;
      if ({o_mem_addr, o_mem_data, o_if_data, o_d_data} !== 128'd0) begin
         errors++; $display("FAIL reset_data: got %h required 0", {o_mem_addr, o_mem_data, o_if_data, o_d_data});
      end
      idle_inputs(); rst = 0; tick();
   endtask

   task automatic test_fetch_hit();
      do_reset();
      i_if_req = 1; i_if_addr = 32'h100; i_mem_data = 32'hDEADBEEF;
      tick();
      checks++;
      if ({o_mem_ren, o_mem_wen, o_mem_addr, o_busy} !== {1'b1, 4'd0, 32'h100, 1'b1}) begin
         errors++; $display("FAIL fetch_issue: ren=%b wen=%b addr=%h busy=%b required 1 0 100 1", o_mem_ren, o_mem_wen, o_mem_addr, o_busy);
      end
      tick();
      checks++;
      if ({o_mem_ren, o_if_ack, o_d_ack} !== 3'b000) begin
         errors++; $display("FAIL fetch_wait: ren/ifack/dack=%b required 000", {o_mem_ren, o_if_ack, o_d_ack});
      end
      tick();
      checks++;
      if ({o_if_ack, o_d_ack, o_if_data} !== {2'b10, 32'hDEADBEEF}) begin
         errors++; $display("FAIL fetch_ack: ifack=%b dack=%b data=%h required 1 0 deadbeef", o_if_ack, o_d_ack, o_if_data);
      end
      i_if_req = 0;
      tick();
      checks++;
      if ({o_if_ack, o_busy, o_mem_ren, o_if_data} !== {3'b000, 32'hDEADBEEF}) begin
         errors++; $display("FAIL fetch_after: ack=%b busy=%b ren=%b data=%h", o_if_ack, o_busy, o_mem_ren, o_if_data);
      end
   endtask

   task automatic test_store_stall();
      int bad;
      do_reset();
      i_d_ren = 1; i_d_addr = 32'h300; i_mem_data = 32'h12345678;
      tick(); tick(); tick();
      checks++;
      if ({o_d_ack, o_d_data} !== {1'b1, 32'h12345678}) begin
         errors++; $display("FAIL load_ack: ack=%b data=%h required 1 12345678", o_d_ack, o_d_data);
      end
      i_d_ren = 0; tick();
      i_d_wen = 4'b0011; i_d_addr = 32'h204; i_d_data = 32'h0000ABCD;
      i_mem_stall = 1; i_mem_data = 32'hFFFFFFFF;
      tick();
      checks++;
      if ({o_mem_ren, o_mem_wen, o_mem_addr, o_mem_data} !== {1'b0, 4'b0011, 32'h204, 32'h0000ABCD}) begin
         errors++; $display("FAIL store_issue: ren=%b wen=%b addr=%h data=%h", o_mem_ren, o_mem_wen, o_mem_addr, o_mem_data);
      end
      tick();
      bad = 0;
      for (int i = 0; i < 21; i++) begin
         if (i == 20) i_mem_stall = 0;
         if ({o_mem_ren, o_mem_wen, o_d_ack, o_if_ack, o_busy, o_mem_addr, o_mem_data} !==
             {7'b0000001, 32'h204, 32'h0000ABCD}) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL store_wait_hold: %0d bad WAIT cycles, required 0", bad);
      end
      checks++;
      if ({o_d_ack, o_d_data} !== {1'b1, 32'h12345678}) begin
         errors++; $display("FAIL store_ack: ack=%b d_data=%h required 1 12345678", o_d_ack, o_d_data);
      end
      i_d_wen = 0; tick();
      checks++;
      if ({o_d_ack, o_busy} !== 2'b00) begin
         errors++; $display("FAIL store_after: ack=%b busy=%b required 00", o_d_ack, o_busy);
      end
   endtask

   task automatic test_ren_wen_both();
      do_reset();
      i_d_ren = 1; i_d_wen = 4'b1111; i_d_addr = 32'h40; i_d_data = $urandom;
      i_mem_data = 32'hBAD0BAD0;
      tick();
      checks++;
      if ({o_mem_ren, o_mem_wen, o_mem_data} !== {1'b0, 4'b1111, i_d_data}) begin
         errors++; $display("FAIL rw_issue: ren=%b wen=%b data=%h required 0 1111 %h", o_mem_ren, o_mem_wen, o_mem_data, i_d_data);
      end
      tick(); tick();
      checks++;
      if ({o_d_ack, o_d_data} !== {1'b1, 32'd0}) begin
         errors++; $display("FAIL rw_ack: ack=%b d_data=%h required 1 0", o_d_ack, o_d_data);
      end
      idle_inputs(); tick();
   endtask

   task automatic test_alternate();
      int bad;
      do_reset();
      i_if_req = 1; i_if_addr = 32'hA0; i_d_ren = 1; i_d_addr = 32'hD0;
      bad = 0;
      for (int k = 0; k < 17; k++) begin
         i_mem_data = 32'hC0DE0000 + k;
         if (o_if_ack !== (k % 8 == 3)) bad++;
         if (o_d_ack !== (k % 8 == 7)) bad++;
         if (o_mem_ren !== (k % 4 == 1)) bad++;
         if (k % 4 == 1 && o_mem_addr !== ((k % 8 == 1) ? 32'hA0 : 32'hD0)) bad++;
         if (k % 8 == 3 && o_if_data !== 32'hC0DE0000 + k - 1) bad++;
         if (k % 8 == 7 && o_d_data !== 32'hC0DE0000 + k - 1) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL alternate: %0d mismatched signal-cycles, required 0", bad);
      end
      idle_inputs(); tick();
   endtask

   task automatic test_reset_wait();
      int bad;
      do_reset();
      i_if_req = 1; i_if_addr = 32'h80;
      tick(); tick(); tick();
      i_if_req = 0; tick();
      i_d_ren = 1; i_d_addr = 32'h900; i_mem_stall = 1;
      tick(); tick(); tick();
      rst = 1; i_d_ren = 0;
      tick();
      checks++;
      if ({o_busy, o_d_ack, o_if_ack} !== 3'b000) begin
         errors++; $display("FAIL rst_wait: busy/dack/ifack=%b required 000", {o_busy, o_d_ack, o_if_ack});
      end
      rst = 0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if ({o_busy, o_d_ack, o_if_ack, o_mem_ren} !== 4'b0000) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL rst_quiet: %0d active cycles, required 0", bad);
      end
      i_if_req = 1; i_if_addr = 32'h600; i_d_ren = 1; i_d_addr = 32'h700; i_mem_stall = 0;
      tick();
      checks++;
      if ({o_mem_ren, o_mem_addr} !== {1'b1, 32'h600}) begin
         errors++; $display("FAIL rst_first_grant: ren=%b addr=%h required 1 600", o_mem_ren, o_mem_addr);
      end
      idle_inputs(); tick(); tick(); tick();
   endtask

   task automatic test_held();
      int bad;
      do_reset();
      i_if_req = 1; i_if_addr = 32'h44;
      bad = 0;
      for (int k = 0; k < 9; k++) begin
         if (o_mem_ren !== (k == 1 || k == 5)) bad++;
         if (o_if_ack !== (k == 3 || k == 7)) bad++;
         if (o_d_ack !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL held_req: %0d mismatched signal-cycles, required 0", bad);
      end
      idle_inputs(); tick(); tick(); tick();
   endtask

   task automatic test_random();
      bit            m_busy, m_lg, m_owner, quiet, dq;
      int            m_start, m_s, w, bad_ctl, bad_dat;
      logic [AW-1:0] m_addr;
      logic [DW-1:0] m_data, m_rd, e_if, e_d;
      logic [3:0]    m_wen;
      bit            e_busy, e_ren, e_ifa, e_da;
      logic [3:0]    e_wen;
      do_reset();
      m_busy = 0; m_lg = 1; m_owner = 0; m_start = 0; m_s = 0;
      m_addr = '0; m_data = '0; m_rd = '0; m_wen = '0; e_if = '0; e_d = '0;
      bad_ctl = 0; bad_dat = 0;
      for (int c = 0; c < 1200; c++) begin
         quiet = (c >= 1150);
         if (!i_if_req && !quiet && $urandom_range(0, 2) == 0) begin
            i_if_req = 1; i_if_addr = $urandom;
         end
         dq = i_d_ren || (i_d_wen != 4'd0);
         if (!dq && !quiet && $urandom_range(0, 2) == 0) begin
            i_d_wen = 4'($urandom_range(0, 15));
            i_d_ren = (i_d_wen == 4'd0) ? 1'b1 : 1'($urandom_range(0, 1));
            i_d_addr = $urandom; i_d_data = $urandom;
         end
         dq = i_d_ren || (i_d_wen != 4'd0);
         if (!m_busy && (i_if_req || dq)) begin
            if (i_if_req && dq) m_owner = !m_lg;
            else                m_owner = dq;
            m_busy = 1; m_start = c; m_s = $urandom_range(0, 4); m_rd = $urandom;
            m_addr = m_owner ? i_d_addr : i_if_addr;
            m_wen  = m_owner ? i_d_wen : 4'd0;
            m_data = i_d_data;
         end
         w = c - m_start;
         if (m_busy && w >= 2 && w < 2 + m_s) i_mem_stall = 1;
         else if (m_busy && w == 2 + m_s)    i_mem_stall = 0;
         else                                i_mem_stall = 1'($urandom_range(0, 1));
         i_mem_data = (m_busy && w == 2 + m_s) ? m_rd : $urandom;
         e_busy = m_busy && w >= 1;
         e_ren  = m_busy && w == 1 && m_wen == 4'd0;
         e_wen  = (m_busy && w == 1) ? m_wen : 4'd0;
         e_ifa  = m_busy && w == 3 + m_s && !m_owner;
         e_da   = m_busy && w == 3 + m_s && m_owner;
         if (e_ifa) e_if = m_rd;
         if (e_da && m_wen == 4'd0) e_d = m_rd;
         if ({o_busy, o_mem_ren, o_mem_wen, o_if_ack, o_d_ack} !== {e_busy, e_ren, e_wen, e_ifa, e_da}) begin
            bad_ctl++;
            if (bad_ctl <= 5) $display("FAIL rand_ctl c=%0d: busy/ren/wen/ifack/dack=%b required %b", c,
               {o_busy, o_mem_ren, o_mem_wen, o_if_ack, o_d_ack}, {e_busy, e_ren, e_wen, e_ifa, e_da});
         end
         if (o_if_data !== e_if || o_d_data !== e_d ||
             (m_busy && w >= 1 && w <= 2 + m_s && o_mem_addr !== m_addr) ||
             (m_busy && m_owner && w >= 1 && w <= 2 + m_s && o_mem_data !== m_data)) begin
            bad_dat++;
            if (bad_dat <= 5) $display("FAIL rand_data c=%0d: if=%h d=%h addr=%h wdata=%h required %h %h %h %h", c,
               o_if_data, o_d_data, o_mem_addr, o_mem_data, e_if, e_d, m_addr, m_data);
         end
         if (m_busy && w == 3 + m_s) begin
            m_busy = 0; m_lg = m_owner;
            if (!m_owner) begin
               if (quiet || $urandom_range(0, 1) == 0) i_if_req = 0;
               else i_if_addr = $urandom;
            end else begin
               if (quiet || $urandom_range(0, 1) == 0) begin i_d_ren = 0; i_d_wen = 0; end
               else begin i_d_addr = $urandom; i_d_data = $urandom; end
            end
         end
         tick();
      end
      checks++;
      if (bad_ctl != 0) begin
         errors++; $display("FAIL rand_ctl_total: %0d bad cycles, required 0", bad_ctl);
      end
      checks++;
      if (bad_dat != 0) begin
         errors++; $display("FAIL rand_data_total: %0d bad cycles, required 0", bad_dat);
      end
      idle_inputs(); tick();
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_fetch_hit();
      test_store_stall();
      test_ren_wen_both();
      test_alternate();
      test_reset_wait();
      test_held();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
